// File: rtl/instr_queue.sv
// instr_queue: DEPTH-entry circular instruction buffer between fetch and decode.
// Each entry carries {adel, pc, instr}. The outputs read the head entry combinationally,
// and a flush or reset empties the queue in one cycle.
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  logic [WIDTH-1:0]           enq_pc,
    input  logic [WIDTH-1:0]           enq_instr,
    output logic                       full,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [WIDTH-1:0]           deq_pc,
    output logic [WIDTH-1:0]           deq_pc_add_4,
    output logic [WIDTH-1:0]           deq_instr,
    output logic                       deq_adel,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Entry storage. It is never reset: the empty forcing on the outputs hides stale contents.
    logic [WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [DEPTH-1:0] adel_mem_q;

    logic empty;
    logic enq_fire;
    logic deq_fire;

    // Handshake decode. Flush overrides both sides, and full refuses enqueue even when a dequeue fires.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CNT_W'(DEPTH));
        deq_valid = !empty;
        enq_fire  = enq_valid && !full && !flush;
        deq_fire  = deq_valid && deq_ready && !flush;
    end

    // Next-state computation for the pointers and the occupancy counter.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq_fire) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register. Reset has the same effect as a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry write at the tail. The misalignment tag is captured at enqueue.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            pc_mem_q[tail_q]    <= enq_pc;
            instr_mem_q[tail_q] <= enq_instr;
            adel_mem_q[tail_q]  <= |enq_pc[1:0];
        end
    end

    // Head read. When the queue is empty, the outputs show a NOP at PC 0.
    always_comb begin
        deq_pc    = '0;
        deq_instr = '0;
        deq_adel  = 1'b0;
        if (!empty) begin
            deq_pc    = pc_mem_q[head_q];
            deq_instr = instr_mem_q[head_q];
            deq_adel  = adel_mem_q[head_q];
        end
        deq_pc_add_4 = deq_pc + WIDTH'(4);
        count        = count_q;
    end

endmodule
